// File: rtl/cache_refill.sv
// cache_pkg: geometry and block types shared by the refill engine and its users.
//
// cache_refill: single-outstanding miss refill engine for a set-associative cache.
//   A miss (set, tag) is accepted in IDLE. The set is snapshotted once (SNAP);
//   if the tag is already present the miss completes immediately as a duplicate.
//   Otherwise a victim is chosen (first invalid way, else round-robin), the block
//   is fetched from memory (REQ/WAIT) and the whole set is written back in one
//   cycle (WRITE). A missing memory response abandons the refill after
//   TimeoutCycles cycles in WAIT.
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   miss_valid_i/miss_ready_o    miss request handshake; miss_set_i, miss_tag_i
//   set_rd_o                     set index for the snapshot read
//   set_info_i, set_data_i       combinational contents of set_rd_o
//   mem_req_valid_o/_ready_i     memory request handshake; mem_req_addr_o = {tag,set}
//   mem_resp_valid_i/_data_i     memory response strobe and fill data
//   write_en_o, write_set_o,
//   write_set_info_o/_data_o     whole-set cache write port
//   busy_o                       refill in progress (state != IDLE)
//   done_o, done_way_o           completion pulse and filled/matched way
//   timeout_o                    abandon pulse
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid and its payload stay stable until that edge.

package cache_pkg;
    localparam int SetWidth      = 2;
    localparam int TagWidth      = 4;
    localparam int DataWidth     = 8;
    localparam int Associativity = 4;
    localparam int WayWidth      = $clog2(Associativity);

    typedef struct packed {
        logic                valid;
        logic [TagWidth-1:0] tag;
    } block_info_t;

    typedef logic [DataWidth-1:0] block_data_t;
endpackage

module cache_refill
    import cache_pkg::*;
#(
    parameter int TimeoutCycles = 64
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 miss_valid_i,
    output logic                                 miss_ready_o,
    input  logic [SetWidth-1:0]                  miss_set_i,
    input  logic [TagWidth-1:0]                  miss_tag_i,
    output logic [SetWidth-1:0]                  set_rd_o,
    input  block_info_t [Associativity-1:0]      set_info_i,
    input  block_data_t [Associativity-1:0]      set_data_i,
    output logic                                 mem_req_valid_o,
    input  logic                                 mem_req_ready_i,
    output logic [TagWidth+SetWidth-1:0]         mem_req_addr_o,
    input  logic                                 mem_resp_valid_i,
    input  logic [DataWidth-1:0]                 mem_resp_data_i,
    output logic                                 write_en_o,
    output logic [SetWidth-1:0]                  write_set_o,
    output block_info_t [Associativity-1:0]      write_set_info_o,
    output block_data_t [Associativity-1:0]      write_set_data_o,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic [WayWidth-1:0]                  done_way_o,
    output logic                                 timeout_o
);

    localparam int CntWidth = $clog2(TimeoutCycles + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SNAP  = 3'd1,
        REQ   = 3'd2,
        WAIT  = 3'd3,
        WRITE = 3'd4
    } state_t;

    state_t                           state_q, state_d;
    logic [SetWidth-1:0]              set_q, set_d;
    logic [TagWidth-1:0]              tag_q, tag_d;
    block_info_t [Associativity-1:0]  info_q, info_d;
    block_data_t [Associativity-1:0]  data_q, data_d;
    logic [WayWidth-1:0]              victim_q, victim_d;
    logic                             full_q, full_d;
    logic [WayWidth-1:0]              rr_q, rr_d;
    logic [CntWidth-1:0]              cnt_q, cnt_d;
    logic [DataWidth-1:0]             resp_q, resp_d;
    logic                             done_q, done_d;
    logic [WayWidth-1:0]              done_way_q, done_way_d;
    logic                             timeout_q, timeout_d;

    // Snapshot lookup: duplicate detection and first free way.
    logic                hit_found;
    logic [WayWidth-1:0] hit_way;
    logic                free_found;
    logic [WayWidth-1:0] free_way;

    always_comb begin
        hit_found  = 1'b0;
        hit_way    = '0;
        free_found = 1'b0;
        free_way   = '0;
        // Descending scan so the lowest matching index wins.
        for (int i = Associativity - 1; i >= 0; i--) begin
            if (set_info_i[i].valid && set_info_i[i].tag == tag_q) begin
                hit_found = 1'b1;
                hit_way   = WayWidth'(i);
            end
            if (!set_info_i[i].valid) begin
                free_found = 1'b1;
                free_way   = WayWidth'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        set_d      = set_q;
        tag_d      = tag_q;
        info_d     = info_q;
        data_d     = data_q;
        victim_d   = victim_q;
        full_d     = full_q;
        rr_d       = rr_q;
        cnt_d      = cnt_q;
        resp_d     = resp_q;
        done_d     = 1'b0;
        done_way_d = '0;
        timeout_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (miss_valid_i) begin
                    set_d   = miss_set_i;
                    tag_d   = miss_tag_i;
                    state_d = SNAP;
                end
            end
            SNAP: begin
                info_d = set_info_i;
                data_d = set_data_i;
                if (hit_found) begin
                    // Block already present: report the matching way, no refill.
                    done_d     = 1'b1;
                    done_way_d = hit_way;
                    state_d    = IDLE;
                end else begin
                    full_d   = !free_found;
                    victim_d = free_found ? free_way : rr_q;
                    state_d  = REQ;
                end
            end
            REQ: begin
                if (mem_req_ready_i) begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_resp_valid_i) begin
                    resp_d     = mem_resp_data_i;
                    done_d     = 1'b1;
                    done_way_d = victim_q;
                    state_d    = WRITE;
                end else if (cnt_q == CntWidth'(TimeoutCycles - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WRITE: begin
                // Pointer moves only when a real eviction of a full set happens.
                if (full_q) begin
                    rr_d = (rr_q == WayWidth'(Associativity - 1)) ? '0 : rr_q + 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            set_q      <= '0;
            tag_q      <= '0;
            info_q     <= '0;
            data_q     <= '0;
            victim_q   <= '0;
            full_q     <= 1'b0;
            rr_q       <= '0;
            cnt_q      <= '0;
            resp_q     <= '0;
            done_q     <= 1'b0;
            done_way_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            set_q      <= set_d;
            tag_q      <= tag_d;
            info_q     <= info_d;
            data_q     <= data_d;
            victim_q   <= victim_d;
            full_q     <= full_d;
            rr_q       <= rr_d;
            cnt_q      <= cnt_d;
            resp_q     <= resp_d;
            done_q     <= done_d;
            done_way_q <= done_way_d;
            timeout_q  <= timeout_d;
        end
    end

    // Outputs decode the registered state; everything rests at 0 outside its state.
    // miss_ready_o is also held low while reset is asserted.
    assign miss_ready_o    = (state_q == IDLE) && !rst_i;
    assign busy_o          = (state_q != IDLE);
    assign set_rd_o        = (state_q == SNAP) ? set_q : '0;
    assign mem_req_valid_o = (state_q == REQ);
    assign mem_req_addr_o  = (state_q == REQ) ? {tag_q, set_q} : '0;
    assign write_en_o      = (state_q == WRITE);
    assign write_set_o     = (state_q == WRITE) ? set_q : '0;
    assign done_o          = done_q;
    assign done_way_o      = done_way_q;
    assign timeout_o       = timeout_q;

    always_comb begin
        write_set_info_o = '0;
        write_set_data_o = '0;
        if (state_q == WRITE) begin
            write_set_info_o                 = info_q;
            write_set_data_o                 = data_q;
            write_set_info_o[victim_q].valid = 1'b1;
            write_set_info_o[victim_q].tag   = tag_q;
            write_set_data_o[victim_q]       = resp_q;
        end
    end

endmodule

// File: doc/cache_refill.md
CACHE_REFILL -- requirements
Module: cache_refill

Interface
REQ-001 SHALL import cache_pkg (SetWidth, TagWidth, DataWidth, Associativity, block_info_t{valid,tag}, block_data_t).
REQ-002 Parameter: TimeoutCycles, default 64, max cycles spent in WAIT before the refill is abandoned.
REQ-003 clk_i  in  1  sole clock; all state updates on posedge.
REQ-004 rst_i  in  1  asynchronous, active-high reset.
REQ-005 miss_valid_i / miss_ready_o  in/out  1  miss request handshake.
REQ-006 miss_set_i  in  SetWidth, and miss_tag_i  in  TagWidth: missed address.
REQ-007 set_rd_o  out  SetWidth  set index presented to the cache snapshot read.
REQ-008 set_info_i  in  block_info_t[Associativity]  current info of set_rd_o (combinational).
REQ-009 set_data_i  in  block_data_t[Associativity]  current data of set_rd_o.
REQ-010 mem_req_valid_o / mem_req_ready_i  out/in  1  memory request handshake.
REQ-011 mem_req_addr_o  out  TagWidth+SetWidth  {tag,set} of the block requested.
REQ-012 mem_resp_valid_i  in  1  response strobe; mem_resp_data_i  in  DataWidth  fill data.
REQ-013 write_en_o  out  1; write_set_o  out  SetWidth; write_set_info_o and write_set_data_o  out  Associativity arrays: whole-set cache write port.
REQ-014 busy_o  out  1  state != IDLE.
REQ-015 done_o  out  1  one-cycle completion pulse; done_way_o  out  $clog2(Associativity)  way filled or matched.
REQ-016 timeout_o  out  1  one-cycle abandon pulse.

Function
REQ-017 FSM states: IDLE, SNAP, REQ, WAIT, WRITE.
REQ-018 IDLE: miss_ready_o=1; on miss_valid_i, latch set/tag and go to SNAP; all other outputs idle at 0.
REQ-019 SNAP (1 cycle): set_rd_o = latched set; register set_info_i and set_data_i.
REQ-020 SNAP: a valid way whose tag equals the latched tag (duplicate) causes done_o=1 and done_way_o = that way in the next cycle, no memory request, no write, then IDLE.
REQ-021 Victim selection otherwise: lowest-index way with valid=0; if every way is valid, the way at the round-robin pointer.
REQ-022 Round-robin pointer: $clog2(Associativity) bits; advances by 1 (wraps Associativity-1 -> 0) only when a fully-valid set is evicted in WRITE.
REQ-023 REQ: mem_req_valid_o=1 with a stable address until mem_req_ready_i; on the handshake go to WAIT and clear the timeout counter.
REQ-024 WAIT: the first mem_resp_valid_i captures mem_resp_data_i and goes to WRITE; mem_resp_valid_i is ignored in every other state.
REQ-025 WAIT timeout: when the counter reaches TimeoutCycles with no response, pulse timeout_o for 1 cycle, make no write, leave the pointer unchanged, and go to IDLE.
REQ-026 WRITE (exactly 1 cycle): write_en_o=1; write_set_o = latched set; arrays = snapshot with victim info = {valid=1, tag} and data = captured data; done_o=1; done_way_o = victim; then IDLE.
REQ-027 Latency with no stalls: miss handshake -> write_en_o is 4 cycles, given mem ready in REQ and a response in the first WAIT cycle.
REQ-028 miss_ready_o=0 whenever busy_o=1; only one refill is outstanding at a time.
REQ-029 The miss handshake SHALL be accepted in the cycle immediately after a WRITE.

Reset
REQ-030 rst_i asserted SHALL immediately force IDLE with the pointer, timeout counter and latches cleared.
REQ-031 Under reset, all outputs SHALL be 0 except miss_ready_o, which is 0 during reset and 1 once in IDLE.
REQ-032 Reset mid-refill SHALL abort with no write_en_o, no done_o and no timeout_o pulse.

Verification
REQ-033 Bench uses Associativity=4. Empty set 2, miss tag 5, response 0xA5 -> write_en_o once, way0 = {1,5,0xA5}, other ways unchanged, done_way_o=0.
REQ-034 Set 1 fully valid with tags 0..3, four misses with tags 8..11 -> victims 0,1,2,3 in order; a fifth miss -> victim 0 again (wrap).
REQ-035 Miss set 3 tag 7 where way2 already holds a valid tag 7 -> done_o with done_way_o=2, mem_req_valid_o never asserted, no write.
REQ-036 mem_req_ready_i held low 10 cycles, then no response for TimeoutCycles -> address held stable while low; timeout_o pulses once, no write, pointer unchanged.
REQ-037 rst_i pulsed in WAIT, then a response arrives -> no write_en_o; busy_o=0; the next miss completes normally.
